// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data requesters onto one shared memory port.
// Data has priority, but a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall_f,
   output logic        stall_m
);

   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          grant_if, grant_d;

   // Next-state, grant selection and starvation counter update
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (if_req && d_req) begin
               if (starve_cnt == CW'(STARVE_MAX)) grant_if = 1'b1;
               else                               grant_d  = 1'b1;
            end else if (if_req) begin
               grant_if = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end

            if (!if_req) starve_nxt = '0;

            if (grant_if) begin
               state_nxt  = IF_BUSY;
               starve_nxt = '0;
            end else if (grant_d) begin
               state_nxt = D_BUSY;
               if (if_req && (starve_cnt < CW'(STARVE_MAX)))
                  starve_nxt = starve_cnt + CW'(1);
            end
         end
         IF_BUSY: if (mem_ack) state_nxt = IDLE;
         D_BUSY:  if (mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, memory-port request registers and per-requester completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_ready   <= 1'b0;
         d_ready    <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         mem_req    <= (state_nxt != IDLE);
         if (grant_if) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
         end else if (grant_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
         end
         if_ready <= (state == IF_BUSY) && mem_ack;
         d_ready  <= (state == D_BUSY) && mem_ack;
         if ((state == IF_BUSY) && mem_ack) if_rdata <= mem_rdata;
         // Store completions leave the load data untouched
         if ((state == D_BUSY) && mem_ack && !mem_we) d_rdata <= mem_rdata;
      end
   end

   assign stall_f = if_req & ~if_ready;
   assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with the default STARVE_MAX of 3.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_f;
   logic        stall_m;

   int checks   = 0;
   int failures = 0;

   mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall_f   (stall_f),
      .stall_m   (stall_m)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic        is_if;
      logic [31:0] exp_addr;

      reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_readys", {30'd0, if_ready, d_ready}, 32'd0);
      reset = 1'b1;

      // Fetch only
      if_req = 1'b1; if_addr = 32'h100;
      #1 chk("f_stall_f_wait", 32'(stall_f), 32'd1);
      tick();
      chk("f_mem_req", 32'(mem_req), 32'd1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_we", 32'(mem_we), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
      tick();
      chk("f_if_ready", 32'(if_ready), 32'd1);
      chk("f_if_rdata", if_rdata, 32'hE3A01005);
      chk("f_mem_req_done", 32'(mem_req), 32'd0);
      chk("f_stall_f_ready", 32'(stall_f), 32'd0);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      chk("f_if_ready_pulse", 32'(if_ready), 32'd0);
      chk("f_if_rdata_hold", if_rdata, 32'hE3A01005);

      // Simultaneous: data write first, then fetch
      if_req = 1'b1; if_addr = 32'h104;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      tick();
      chk("s_d_addr", mem_addr, 32'h200);
      chk("s_d_we", 32'(mem_we), 32'd1);
      chk("s_d_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_stall_f1", 32'(stall_f), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      tick();
      chk("s_d_ready", 32'(d_ready), 32'd1);
      chk("s_d_rdata_write", d_rdata, 32'd0);
      chk("s_stall_f2", 32'(stall_f), 32'd1);
      d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      tick();
      chk("s_if_addr", mem_addr, 32'h104);
      chk("s_if_we", 32'(mem_we), 32'd0);
      chk("s_stall_f3", 32'(stall_f), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h11111111;
      tick();
      chk("s_if_ready", 32'(if_ready), 32'd1);
      chk("s_if_rdata", if_rdata, 32'h11111111);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();

      // Starvation: both held high, expect D,D,D,IF,D,D,D,IF
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      tick();
      for (int i = 0; i < 8; i++) begin
         is_if    = (i == 3) || (i == 7);
         exp_addr = is_if ? 32'h400 : 32'h500;
         chk($sformatf("st_addr%0d", i), mem_addr, exp_addr);
         chk($sformatf("st_req%0d", i), 32'(mem_req), 32'd1);
         mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(i);
         tick();
         chk($sformatf("st_ready%0d", i), {30'd0, if_ready, d_ready},
             is_if ? 32'd2 : 32'd1);
         mem_ack = 1'b0;
         if (i == 7) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         tick();
      end
      chk("st_if_rdata", if_rdata, 32'hA7);
      chk("st_d_rdata", d_rdata, 32'hA6);

      // Wait states on a data read
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("w_req%0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("w_addr%0d", i), mem_addr, 32'h300);
         chk($sformatf("w_stall%0d", i), 32'(stall_m), 32'd1);
         tick();
      end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk("w_d_ready", 32'(d_ready), 32'd1);
      chk("w_d_rdata", d_rdata, 32'hCAFEF00D);
      chk("w_stall_m", 32'(stall_m), 32'd0);
      d_req = 1'b0; mem_ack = 1'b0;
      tick();

      // Spurious ack while idle
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick(); tick();
      chk("sp_mem_req", 32'(mem_req), 32'd0);
      chk("sp_readys", {30'd0, if_ready, d_ready}, 32'd0);
      chk("sp_d_rdata", d_rdata, 32'hCAFEF00D);
      chk("sp_if_rdata", if_rdata, 32'hA7);
      mem_ack = 1'b0;

      // Reset during D_BUSY, then reissue
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'hA5A5A5A5;
      tick();
      chk("r_busy", 32'(mem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("r_mem_req_async", 32'(mem_req), 32'd0);
      chk("r_mem_addr_async", mem_addr, 32'd0);
      tick();
      chk("r_no_ready", 32'(d_ready), 32'd0);
      reset = 1'b1;
      tick();
      chk("r_reissue_req", 32'(mem_req), 32'd1);
      chk("r_reissue_addr", mem_addr, 32'h600);
      chk("r_reissue_we", 32'(mem_we), 32'd1);
      mem_ack = 1'b1;
      tick();
      chk("r_d_ready", 32'(d_ready), 32'd1);
      chk("r_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      tick();

      // Request dropped mid-transaction still completes
      d_req = 1'b1; d_addr = 32'h700;
      tick();
      d_req = 1'b0;
      tick();
      chk("a_mem_req_held", 32'(mem_req), 32'd1);
      chk("a_addr_held", mem_addr, 32'h700);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF0001;
      tick();
      chk("a_d_ready", 32'(d_ready), 32'd1);
      chk("a_d_rdata", d_rdata, 32'hBEEF0001);
      mem_ack = 1'b0;
      tick();
      chk("a_idle", 32'(mem_req), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
